// File: rtl/display_pkg.sv
// Shared definitions for the rotating LED display datapath.
package display_pkg;

  localparam int unsigned DEFAULT_NR_COL = 128;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_ACQUIRE = 2'd1,
    STATE_RUN     = 2'd2
  } state_t;

endpackage

// File: rtl/plus1.sv
// Incrementer shared by the revolution counter and the column index.
module plus1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_a + WIDTH'(1);

endmodule

// File: rtl/sensor_sync.sv
// Two-flop synchroniser for the raw sync sensor plus a one-cycle rise pulse.
module sensor_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_sensor,
  output logic o_rise_c
);

  logic r_sync1;
  logic r_sync2;
  logic r_dly;

  // Metastability filter followed by a delay flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
      r_dly   <= r_sync2;
    end
  end

  assign o_rise_c = r_sync2 & ~r_dly;

endmodule

// File: rtl/column_sequencer.sv
// Turns the rotation sync sensor into a revolution period (divider numerator)
// and steps a column index with one-cycle strobes using the divider quotient.
// Optional feature: define SYNC_TIMEOUT_EN to drop back to IDLE when the
// revolution counter saturates while acquiring or running.
module column_sequencer
  import display_pkg::*;
#(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned NR_COL     = DEFAULT_NR_COL,
  parameter int unsigned COL_WIDTH  = 7,
  parameter int unsigned MIN_PERIOD = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sensor,
  input  logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     period,
  output logic [WIDTH-1:0]     denominator,
  output logic [COL_WIDTH-1:0] column,
  output logic                 column_strobe,
  output logic                 frame_start,
  output logic                 locked
);

  localparam logic [WIDTH-1:0]     CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]     MIN_P    = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0]     TICK_ONE = WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(NR_COL - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_tick;

  logic                 w_rise;
  logic [WIDTH-1:0]     w_cnt_inc;
  logic [WIDTH-1:0]     w_cnt_sat;
  logic [WIDTH-1:0]     w_load;
  logic [COL_WIDTH-1:0] w_col_inc;
  logic                 w_accept;
  logic                 w_timeout;

  sensor_sync u_sensor_sync (
    .clock    (clock),
    .reset    (reset),
    .i_sensor (sensor),
    .o_rise_c (w_rise)
  );

  plus1 #(.WIDTH(WIDTH)) u_cnt_inc (
    .i_a (r_cnt),
    .o_y (w_cnt_inc)
  );

  plus1 #(.WIDTH(COL_WIDTH)) u_col_inc (
    .i_a (column),
    .o_y (w_col_inc)
  );

  // Saturated cnt+1 is both the glitch-filter metric and the recorded period.
  assign w_cnt_sat = (r_cnt == CNT_MAX) ? CNT_MAX : w_cnt_inc;
  assign w_accept  = w_rise & ((r_state == STATE_IDLE) | (w_cnt_sat >= MIN_P));
  assign w_load    = (quotient == '0) ? TICK_ONE : quotient;

  // Loss of sync: counter about to saturate without a fresh revolution mark.
`ifdef SYNC_TIMEOUT_EN
  assign w_timeout = (r_state != STATE_IDLE) & (w_cnt_sat == CNT_MAX) & ~w_accept;
`else
  assign w_timeout = 1'b0;
`endif

  assign denominator = WIDTH'(NR_COL);

  // Revolution FSM, period measurement and column stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= STATE_IDLE;
      r_cnt         <= '0;
      r_tick        <= '0;
      period        <= '0;
      column        <= '0;
      column_strobe <= 1'b0;
      frame_start   <= 1'b0;
      locked        <= 1'b0;
    end else begin
      column_strobe <= 1'b0;
      frame_start   <= 1'b0;
      r_cnt         <= w_accept ? '0 : w_cnt_sat;

      if (w_timeout) begin
        r_state <= STATE_IDLE;
        locked  <= 1'b0;
        column  <= '0;
        period  <= '0;
      end else begin
        case (r_state)
          STATE_IDLE: begin
            if (w_accept) r_state <= STATE_ACQUIRE;
          end
          STATE_ACQUIRE, STATE_RUN: begin
            if (w_accept) begin
              r_state       <= STATE_RUN;
              locked        <= 1'b1;
              period        <= w_cnt_sat;
              column        <= '0;
              column_strobe <= 1'b1;
              frame_start   <= 1'b1;
              r_tick        <= w_load;
            end else if (r_state == STATE_RUN) begin
              if (r_tick == TICK_ONE) begin
                // Last column holds until the next sync; no wrap.
                if (column != LAST_COL) begin
                  column        <= w_col_inc;
                  column_strobe <= 1'b1;
                  r_tick        <= w_load;
                end
              end else begin
                r_tick <= r_tick - TICK_ONE;
              end
            end
          end
          default: begin
            r_state <= STATE_IDLE;
          end
        endcase
      end
    end
  end

endmodule
